// File: rtl/four_bank_mem_pkg.sv
// Shared constants and types for the four-bank interleaved word memory.
package four_bank_mem_pkg;

  localparam int DW           = 16;
  localparam int AW           = 16;
  localparam int NBANK        = 4;
  localparam int BANK_LSB     = 1;
  localparam int BANK_MSB     = 2;
  localparam int ROW_LSB      = 3;
  localparam int ROW_W        = AW - ROW_LSB;
  localparam int DEPTH        = 1 << ROW_W;
  localparam int BUSY_CYC_DEF = 3;
  localparam int RD_LAT_DEF   = 2;

  typedef logic [DW-1:0]                word_t;
  typedef logic [ROW_W-1:0]             row_t;
  typedef logic [BANK_MSB-BANK_LSB:0]   bank_t;

  // One stage of the read-return pipe.
  typedef struct packed {
    logic  valid;
    word_t data;
  } rd_slot_t;

endpackage

// File: rtl/four_bank_mem_if.sv
// Request/response bundle between the cache controller and main memory.
//
// Handshake: a request (rd or wr) is taken in the same cycle it is presented
// exactly when err=0 and stall=0 in that cycle. On stall or err nothing changes
// inside the memory and the initiator keeps the request (or drops it) and
// retries; there is no separate ready signal. A taken read answers with a
// single-cycle rd_valid pulse carrying data_out a fixed latency later.
import four_bank_mem_pkg::*;

interface four_bank_mem_if;
  logic             rd;
  logic             wr;
  logic [AW-1:0]    addr;
  logic [DW-1:0]    data_in;
  logic [DW-1:0]    data_out;
  logic             rd_valid;
  logic             stall;
  logic [NBANK-1:0] busy;
  logic             err;

  modport master (
    output rd, wr, addr, data_in,
    input  data_out, rd_valid, stall, busy, err
  );

  modport slave (
    input  rd, wr, addr, data_in,
    output data_out, rd_valid, stall, busy, err
  );
endinterface

// File: rtl/four_bank_mem_bank.sv
// One memory bank: word storage plus the occupancy down-counter that keeps the
// bank busy for BUSY_CYC cycles after every taken request.
module four_bank_mem_bank
  import four_bank_mem_pkg::*;
#(
  parameter int BUSY_CYC = BUSY_CYC_DEF
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  logic  we,
  input  row_t  row,
  input  word_t wdata,
  output word_t rdata,
  output logic  busy
);

  localparam int            CW   = $clog2(BUSY_CYC + 1);
  localparam logic [CW-1:0] LOAD = CW'(BUSY_CYC);

  word_t         mem [DEPTH];
  logic [CW-1:0] cnt;

  // Storage write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[row] <= wdata;
    end
  end

  // The top samples this into its read pipe at the accept edge.
  assign rdata = mem[row];

  // Occupancy counter: reload on accept, otherwise count down to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= LOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/four_bank_mem.sv
// Four interleaved banks behind one request port: decodes the request, rejects
// illegal or busy-bank requests, and returns read data through a fixed-latency pipe.
module four_bank_mem
  import four_bank_mem_pkg::*;
#(
  parameter int BUSY_CYC = BUSY_CYC_DEF,
  parameter int RD_LAT   = RD_LAT_DEF
) (
  input logic             clk,
  input logic             rst,
  four_bank_mem_if.slave  bus
);

  logic             req;
  logic             bad;
  logic             blocked;
  logic             accept;
  logic             rd_accept;
  bank_t            bank_sel;
  row_t             row;
  logic [NBANK-1:0] busy_vec;
  word_t            bank_rdata [NBANK];
  rd_slot_t         pipe [RD_LAT];

  assign bank_sel = bus.addr[BANK_MSB:BANK_LSB];
  assign row      = bus.addr[AW-1:ROW_LSB];

  // Same-cycle request decode: illegal requests win over busy-bank stalls.
  always_comb begin
    req       = bus.rd | bus.wr;
    bad       = (bus.rd & bus.wr) | (req & bus.addr[0]);
    blocked   = req & ~bad & busy_vec[bank_sel];
    accept    = req & ~bad & ~busy_vec[bank_sel];
    rd_accept = accept & bus.rd;
  end

  assign bus.err   = bad;
  assign bus.stall = blocked;
  assign bus.busy  = busy_vec;

  for (genvar g = 0; g < NBANK; g++) begin : g_bank
    four_bank_mem_bank #(
      .BUSY_CYC (BUSY_CYC)
    ) u_bank (
      .clk   (clk),
      .rst   (rst),
      .en    (accept && (bank_sel == bank_t'(g))),
      .we    (bus.wr),
      .row   (row),
      .wdata (bus.data_in),
      .rdata (bank_rdata[g]),
      .busy  (busy_vec[g])
    );
  end

  // Read-return shift pipe; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0].valid <= rd_accept;
      pipe[0].data  <= rd_accept ? bank_rdata[bank_sel] : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign bus.rd_valid = pipe[RD_LAT-1].valid;
  assign bus.data_out = pipe[RD_LAT-1].valid ? pipe[RD_LAT-1].data : '0;

endmodule

// File: tb/tb_four_bank_mem.sv
// Bench for four_bank_mem: directed cycle table, a reset sequence, and a random
// phase checked against an address-level reference model.
module tb_four_bank_mem;

  localparam int BUSY_CYC = 3;
  localparam int RD_LAT   = 2;

  logic clk;
  logic rst;
  four_bank_mem_if bus ();

  four_bank_mem #(
    .BUSY_CYC (BUSY_CYC),
    .RD_LAT   (RD_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        rst;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] din;
    logic        err;
    logic        stall;
    logic [3:0]  busy;
    logic        rv;
    logic [15:0] dout;
  } vec_t;

  vec_t vecs[$];

  // Reference model state (random phase)
  int          cyc;
  int          free_at [4];
  logic [15:0] ref_mem [int];
  int          due_q[$];
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [15:0] addr,
                              input logic [15:0] din, input logic err, input logic stall,
                              input logic [3:0] busy, input logic rv, input logic [15:0] dout);
    vec_t v;
    v.rst = 1'b0; v.rd = rd; v.wr = wr; v.addr = addr; v.din = din;
    v.err = err; v.stall = stall; v.busy = busy; v.rv = rv; v.dout = dout;
    return v;
  endfunction

  function automatic vec_t vi(input logic [3:0] busy, input logic rv, input logic [15:0] dout);
    return mk(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, busy, rv, dout);
  endfunction

  function automatic vec_t vr(input logic [15:0] addr, input logic stall, input logic [3:0] busy,
                              input logic rv, input logic [15:0] dout);
    return mk(1'b1, 1'b0, addr, 16'h0, 1'b0, stall, busy, rv, dout);
  endfunction

  function automatic vec_t vw(input logic [15:0] addr, input logic [15:0] din, input logic stall,
                              input logic [3:0] busy, input logic rv, input logic [15:0] dout);
    return mk(1'b0, 1'b1, addr, din, 1'b0, stall, busy, rv, dout);
  endfunction

  // Driver: apply one cycle's inputs just after the edge, compare mid-cycle.
  task automatic apply_vec(input vec_t v, input string tag);
    @(posedge clk);
    #1;
    rst         = v.rst;
    bus.rd      = v.rd;
    bus.wr      = v.wr;
    bus.addr    = v.addr;
    bus.data_in = v.din;
    #1;
    check({tag, ".err"},      32'(bus.err),      32'(v.err));
    check({tag, ".stall"},    32'(bus.stall),    32'(v.stall));
    check({tag, ".busy"},     32'(bus.busy),     32'(v.busy));
    check({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'(v.rv));
    check({tag, ".data_out"}, 32'(bus.data_out), 32'(v.dout));
  endtask

  // Driver + model for one random cycle; took reports whether the model expects acceptance.
  task automatic rand_cycle(input logic r, input logic w, input logic [15:0] a,
                            input logic [15:0] d, output logic took);
    int          b;
    int          word;
    logic [3:0]  eb;
    logic        rq, e_err, e_stall, e_rv;
    logic [15:0] e_d;
    @(posedge clk);
    #1;
    rst         = 1'b0;
    bus.rd      = r;
    bus.wr      = w;
    bus.addr    = a;
    bus.data_in = d;
    #1;
    cyc++;
    word = int'(a) / 2;
    b    = word % 4;
    for (int k = 0; k < 4; k++) eb[k] = (cyc < free_at[k]);
    rq      = r | w;
    e_err   = (r & w) | (rq & (a % 2 == 1));
    e_stall = rq & ~e_err & eb[b];
    took    = rq & ~e_err & ~eb[b];
    e_rv    = 1'b0;
    e_d     = 16'h0;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      e_rv = 1'b1;
      e_d  = exp_q[0];
      void'(due_q.pop_front());
      void'(exp_q.pop_front());
    end
    check($sformatf("rnd%0d.err", cyc),      32'(bus.err),      32'(e_err));
    check($sformatf("rnd%0d.stall", cyc),    32'(bus.stall),    32'(e_stall));
    check($sformatf("rnd%0d.busy", cyc),     32'(bus.busy),     32'(eb));
    check($sformatf("rnd%0d.rd_valid", cyc), 32'(bus.rd_valid), 32'(e_rv));
    check($sformatf("rnd%0d.data_out", cyc), 32'(bus.data_out), 32'(e_d));
    if (took) begin
      free_at[b] = cyc + BUSY_CYC + 1;
      if (w) begin
        ref_mem[word] = d;
      end else begin
        due_q.push_back(cyc + RD_LAT);
        exp_q.push_back(ref_mem[word]);
      end
    end
  endtask

  initial begin
    vec_t        v;
    logic        took;
    logic [15:0] a;
    int          tries;
    int          op;

    // Reset
    rst = 1'b1;
    bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.data_in = '0;
    repeat (2) @(posedge clk);

    // Write then read after the bank frees
    vecs.push_back(vw(16'h0010, 16'hBEEF, 0, 4'b0000, 0, 16'h0));
    vecs.push_back(vi(4'b0001, 0, 16'h0));
    vecs.push_back(vi(4'b0001, 0, 16'h0));
    vecs.push_back(vi(4'b0001, 0, 16'h0));
    vecs.push_back(vi(4'b0000, 0, 16'h0));
    vecs.push_back(vr(16'h0010, 0, 4'b0000, 0, 16'h0));
    vecs.push_back(vi(4'b0001, 0, 16'h0));
    vecs.push_back(vi(4'b0001, 1, 16'hBEEF));
    vecs.push_back(vi(4'b0001, 0, 16'h0));
    vecs.push_back(vi(4'b0000, 0, 16'h0));
    // Fill a line, then stream it back on consecutive cycles
    vecs.push_back(vw(16'h0040, 16'h1111, 0, 4'b0000, 0, 16'h0));
    vecs.push_back(vw(16'h0042, 16'h2222, 0, 4'b0001, 0, 16'h0));
    vecs.push_back(vw(16'h0044, 16'h3333, 0, 4'b0011, 0, 16'h0));
    vecs.push_back(vw(16'h0046, 16'h4444, 0, 4'b0111, 0, 16'h0));
    vecs.push_back(vi(4'b1110, 0, 16'h0));
    vecs.push_back(vi(4'b1100, 0, 16'h0));
    vecs.push_back(vi(4'b1000, 0, 16'h0));
    vecs.push_back(vi(4'b0000, 0, 16'h0));
    vecs.push_back(vr(16'h0040, 0, 4'b0000, 0, 16'h0));
    vecs.push_back(vr(16'h0042, 0, 4'b0001, 0, 16'h0));
    vecs.push_back(vr(16'h0044, 0, 4'b0011, 1, 16'h1111));
    vecs.push_back(vr(16'h0046, 0, 4'b0111, 1, 16'h2222));
    vecs.push_back(vi(4'b1110, 1, 16'h3333));
    vecs.push_back(vi(4'b1100, 1, 16'h4444));
    vecs.push_back(vi(4'b1000, 0, 16'h0));
    vecs.push_back(vi(4'b0000, 0, 16'h0));
    // Same-bank back-to-back: stall until the bank frees
    vecs.push_back(vw(16'h0048, 16'h5555, 0, 4'b0000, 0, 16'h0));
    vecs.push_back(vi(4'b0001, 0, 16'h0));
    vecs.push_back(vi(4'b0001, 0, 16'h0));
    vecs.push_back(vi(4'b0001, 0, 16'h0));
    vecs.push_back(vi(4'b0000, 0, 16'h0));
    vecs.push_back(vr(16'h0040, 0, 4'b0000, 0, 16'h0));
    vecs.push_back(vr(16'h0048, 1, 4'b0001, 0, 16'h0));
    vecs.push_back(vr(16'h0048, 1, 4'b0001, 1, 16'h1111));
    vecs.push_back(vr(16'h0048, 1, 4'b0001, 0, 16'h0));
    vecs.push_back(vr(16'h0048, 0, 4'b0000, 0, 16'h0));
    vecs.push_back(vi(4'b0001, 0, 16'h0));
    vecs.push_back(vi(4'b0001, 1, 16'h5555));
    vecs.push_back(vi(4'b0001, 0, 16'h0));
    vecs.push_back(vi(4'b0000, 0, 16'h0));
    // Illegal requests change nothing
    vecs.push_back(mk(1, 1, 16'h0040, 16'h9999, 1, 0, 4'b0000, 0, 16'h0));
    vecs.push_back(mk(1, 0, 16'h0011, 16'h0000, 1, 0, 4'b0000, 0, 16'h0));
    vecs.push_back(mk(0, 1, 16'h0041, 16'h9999, 1, 0, 4'b0000, 0, 16'h0));
    vecs.push_back(vi(4'b0000, 0, 16'h0));
    vecs.push_back(vr(16'h0040, 0, 4'b0000, 0, 16'h0));
    vecs.push_back(mk(1, 1, 16'h0040, 16'h9999, 1, 0, 4'b0001, 0, 16'h0));
    vecs.push_back(vi(4'b0001, 1, 16'h1111));
    vecs.push_back(vi(4'b0001, 0, 16'h0));
    vecs.push_back(vi(4'b0000, 0, 16'h0));
    // Read-after-write to the same bank
    vecs.push_back(vw(16'h0002, 16'hABCD, 0, 4'b0000, 0, 16'h0));
    vecs.push_back(vi(4'b0010, 0, 16'h0));
    vecs.push_back(vi(4'b0010, 0, 16'h0));
    vecs.push_back(vr(16'h0002, 1, 4'b0010, 0, 16'h0));
    vecs.push_back(vr(16'h0002, 0, 4'b0000, 0, 16'h0));
    vecs.push_back(vi(4'b0010, 0, 16'h0));
    vecs.push_back(vi(4'b0010, 1, 16'hABCD));
    vecs.push_back(vi(4'b0010, 0, 16'h0));
    vecs.push_back(vi(4'b0000, 0, 16'h0));

    foreach (vecs[i]) apply_vec(vecs[i], $sformatf("v%0d", i));

    // Reset while a read is in flight: the read is dropped, data survives
    apply_vec(vr(16'h0010, 0, 4'b0000, 0, 16'h0), "rst.t");
    v = vi(4'b0001, 0, 16'h0);
    v.rst = 1'b1;
    apply_vec(v, "rst.t1");
    apply_vec(vi(4'b0000, 0, 16'h0), "rst.t2");
    apply_vec(vi(4'b0000, 0, 16'h0), "rst.t3");
    apply_vec(vr(16'h0010, 0, 4'b0000, 0, 16'h0), "rst.t4");
    apply_vec(vi(4'b0001, 0, 16'h0), "rst.t5");
    apply_vec(vi(4'b0001, 1, 16'hBEEF), "rst.t6");
    apply_vec(vi(4'b0001, 0, 16'h0), "rst.t7");
    apply_vec(vi(4'b0000, 0, 16'h0), "rst.t8");

    // Random phase against the reference model, starting from a clean reset
    v = vi(4'b0000, 0, 16'h0);
    v.rst = 1'b1;
    apply_vec(v, "rnd.rst");
    cyc = 0;
    for (int k = 0; k < 4; k++) free_at[k] = 0;
    due_q.delete();
    exp_q.delete();

    for (int k = 0; k < 16; k++) begin
      a = 16'h0100 + 16'(2 * k);
      tries = 0;
      do begin
        rand_cycle(1'b0, 1'b1, a, 16'($urandom), took);
        tries++;
      end while (!took && tries < 8);
    end

    for (int n = 0; n < 500; n++) begin
      op = $urandom_range(0, 9);
      a  = 16'h0100 + 16'(2 * $urandom_range(0, 15));
      if (op < 2) begin
        rand_cycle(1'b0, 1'b0, a, 16'h0, took);
      end else if (op < 6) begin
        rand_cycle(1'b1, 1'b0, a, 16'h0, took);
      end else if (op < 9) begin
        rand_cycle(1'b0, 1'b1, a, 16'($urandom), took);
      end else if ($urandom_range(0, 1) == 0) begin
        rand_cycle(1'b1, 1'b1, a, 16'($urandom), took);
      end else begin
        rand_cycle(1'b1, 1'b0, a | 16'h0001, 16'h0, took);
      end
    end

    // Drain outstanding returns
    for (int n = 0; n < RD_LAT + 1; n++) rand_cycle(1'b0, 1'b0, 16'h0, 16'h0, took);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
